alarm_mode_ctrl: RTL and testbench

ALARM_MODE_CTRL -- requirements
Module: alarm_mode_ctrl

---
 rtl/alarm_mode_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_alarm_mode_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_mode_ctrl.sv
// alarm_mode_ctrl: alarm clock with time and alarm setting modes.
//
// A prescaler divides clk into a 1 s tick and a 0.5 s half-tick. Time
// (hr:min:sec) advances on each tick. Five single-cycle buttons let the user
// set the time and alarm fields. When the time reaches the alarm, the block
// rings until a button is pressed or RING_SECS ticks pass.
//
// Parameters:
//   TICK_DIV  : clk cycles per 1 s tick (>= 2)
//   HOURS     : hour modulus (12 or 24)
//   RING_SECS : seconds of ringing before auto-dismiss (1..255)
//
// Ports:
//   clk                            : system clock
//   rst                            : asynchronous reset, active low
//   btn_c/u/d/l/r                  : debounced single-cycle button pulses
//   digits[15:0]                   : BCD hh:mm (time, or alarm while setting it)
//   mode_led[4:0]                  : one-hot CLOCK/SET_TH/SET_TM/SET_AH/SET_AM, all 0 in RING
//   blink                          : 0.5 s toggle while a field is being edited
//   ringing                        : high while the alarm rings
//   colon                          : 0.5 s toggle in CLOCK/RING, steady 1 while setting
//
// Optional feature: define ALARM_SNOOZE_EN to add snooze. btn_u in RING then
// arms a one-shot alarm at alarm time + 5 min.

module alarm_mode_ctrl #(
   parameter int unsigned TICK_DIV  = 100000000,
   parameter int unsigned HOURS     = 24,
   parameter int unsigned RING_SECS = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_c,
   input  logic        btn_u,
   input  logic        btn_d,
   input  logic        btn_l,
   input  logic        btn_r,
   output logic [15:0] digits,
   output logic [4:0]  mode_led,
   output logic        blink,
   output logic        ringing,
   output logic        colon
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      ST_CLOCK,
      ST_SET_TH,
      ST_SET_TM,
      ST_SET_AH,
      ST_SET_AM,
      ST_RING
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] pre_q;
   logic          half_q;
   logic [5:0]    sec_q, sec_d, min_q, min_d, hr_q, hr_d;
   logic [5:0]    amin_q, amin_d, ahr_q, ahr_d;
   logic [7:0]    ring_q, ring_d;

   logic          tick, half_tick, time_run, match;
   logic          btn_ok, pc, pu, pd, pl, pr;
   logic          in_set, show_alarm;
   logic [4:0]    btn_vec;

`ifdef ALARM_SNOOZE_EN
   logic          snz_arm_q, snz_arm_d;
   logic [5:0]    snz_min_q, snz_min_d, snz_hr_q, snz_hr_d;
`endif

   function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
      return (v == top) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] top);
      return (v == 6'd0) ? top : v - 6'd1;
   endfunction

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

   // Prescaler and half-second phase. Both run in every state.
   assign tick      = (pre_q == PW'(TICK_DIV - 1));
   assign half_tick = tick || (pre_q == PW'(TICK_DIV / 2 - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q  <= '0;
         half_q <= 1'b0;
      end else begin
         pre_q  <= tick ? '0 : pre_q + 1'b1;
         if (half_tick) begin
            half_q <= ~half_q;
         end
      end
   end

   // A button press counts only when exactly one button is high.
   assign btn_vec = {btn_c, btn_u, btn_d, btn_l, btn_r};
   assign btn_ok  = $onehot(btn_vec);
   assign pc      = btn_ok & btn_c;
   assign pu      = btn_ok & btn_u;
   assign pd      = btn_ok & btn_d;
   assign pl      = btn_ok & btn_l;
   assign pr      = btn_ok & btn_r;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_CLOCK;
         sec_q   <= '0;
         min_q   <= '0;
         hr_q    <= '0;
         amin_q  <= '0;
         ahr_q   <= '0;
         ring_q  <= '0;
`ifdef ALARM_SNOOZE_EN
         snz_arm_q <= 1'b0;
         snz_min_q <= '0;
         snz_hr_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hr_q    <= hr_d;
         amin_q  <= amin_d;
         ahr_q   <= ahr_d;
         ring_q  <= ring_d;
`ifdef ALARM_SNOOZE_EN
         snz_arm_q <= snz_arm_d;
         snz_min_q <= snz_min_d;
         snz_hr_q  <= snz_hr_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      sec_d    = sec_q;
      min_d    = min_q;
      hr_d     = hr_q;
      amin_d   = amin_q;
      ahr_d    = ahr_q;
      ring_d   = ring_q;
`ifdef ALARM_SNOOZE_EN
      snz_arm_d = snz_arm_q;
      snz_min_d = snz_min_q;
      snz_hr_d  = snz_hr_q;
`endif

      // Time stops only while a time field is being edited.
      time_run = tick && (state_q != ST_SET_TH) && (state_q != ST_SET_TM);
      if (time_run) begin
         sec_d = wrap_inc(sec_q, 6'd59);
         if (sec_q == 6'd59) begin
            min_d = wrap_inc(min_q, 6'd59);
            if (min_q == 6'd59) begin
               hr_d = wrap_inc(hr_q, 6'(HOURS - 1));
            end
         end
      end

      // Compare against the post-carry time so the match lands on the
      // tick where sec rolls over to 0.
      match = time_run && (sec_q == 6'd59) && ({hr_d, min_d} == {ahr_q, amin_q});
`ifdef ALARM_SNOOZE_EN
      if (time_run && (sec_q == 6'd59) && snz_arm_q &&
          ({hr_d, min_d} == {snz_hr_q, snz_min_q})) begin
         match = 1'b1;
      end
`endif

      case (state_q)
         ST_CLOCK: begin
            if (pc) begin
               state_d = ST_SET_TH;
`ifdef ALARM_SNOOZE_EN
               snz_arm_d = 1'b0;
`endif
            end else if (match) begin
               state_d = ST_RING;
               ring_d  = '0;
`ifdef ALARM_SNOOZE_EN
               snz_arm_d = 1'b0;
`endif
            end
         end
         ST_SET_TH: begin
            if (pc)      state_d = ST_CLOCK;
            else if (pr) state_d = ST_SET_TM;
            else if (pl) state_d = ST_SET_AM;
            else if (pu) begin
               hr_d  = wrap_inc(hr_q, 6'(HOURS - 1));
               sec_d = '0;
            end else if (pd) begin
               hr_d  = wrap_dec(hr_q, 6'(HOURS - 1));
               sec_d = '0;
            end
         end
         ST_SET_TM: begin
            if (pc)      state_d = ST_CLOCK;
            else if (pr) state_d = ST_SET_AH;
            else if (pl) state_d = ST_SET_TH;
            else if (pu) begin
               min_d = wrap_inc(min_q, 6'd59);
               sec_d = '0;
            end else if (pd) begin
               min_d = wrap_dec(min_q, 6'd59);
               sec_d = '0;
            end
         end
         ST_SET_AH: begin
            if (pc)      state_d = ST_CLOCK;
            else if (pr) state_d = ST_SET_AM;
            else if (pl) state_d = ST_SET_TM;
            else if (pu) ahr_d = wrap_inc(ahr_q, 6'(HOURS - 1));
            else if (pd) ahr_d = wrap_dec(ahr_q, 6'(HOURS - 1));
         end
         ST_SET_AM: begin
            if (pc)      state_d = ST_CLOCK;
            else if (pr) state_d = ST_SET_TH;
            else if (pl) state_d = ST_SET_AH;
            else if (pu) amin_d = wrap_inc(amin_q, 6'd59);
            else if (pd) amin_d = wrap_dec(amin_q, 6'd59);
         end
         ST_RING: begin
            if (btn_ok) begin
               state_d = ST_CLOCK;
`ifdef ALARM_SNOOZE_EN
               if (pu) begin
                  snz_arm_d = 1'b1;
                  if (amin_q >= 6'd55) begin
                     snz_min_d = amin_q - 6'd55;
                     snz_hr_d  = wrap_inc(ahr_q, 6'(HOURS - 1));
                  end else begin
                     snz_min_d = amin_q + 6'd5;
                     snz_hr_d  = ahr_q;
                  end
               end
`endif
            end else if (tick) begin
               if (ring_q == 8'(RING_SECS - 1)) state_d = ST_CLOCK;
               else                             ring_d  = ring_q + 8'd1;
            end
         end
         default: state_d = ST_CLOCK;
      endcase
   end

   // Outputs are decoded from registered state.
   assign in_set     = (state_q == ST_SET_TH) || (state_q == ST_SET_TM) ||
                       (state_q == ST_SET_AH) || (state_q == ST_SET_AM);
   assign show_alarm = (state_q == ST_SET_AH) || (state_q == ST_SET_AM);
   assign blink      = in_set & half_q;
   assign colon      = in_set | half_q;
   assign ringing    = (state_q == ST_RING);
   assign digits     = {to_bcd(show_alarm ? ahr_q : hr_q),
                        to_bcd(show_alarm ? amin_q : min_q)};

   always_comb begin
      mode_led = '0;
      case (state_q)
         ST_CLOCK:  mode_led = 5'b00001;
         ST_SET_TH: mode_led = 5'b00010;
         ST_SET_TM: mode_led = 5'b00100;
         ST_SET_AH: mode_led = 5'b01000;
         ST_SET_AM: mode_led = 5'b10000;
         default:   mode_led = '0;
      endcase
   end

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Directed testbench for alarm_mode_ctrl with TICK_DIV=4 and RING_SECS=3.
// The main instance uses HOURS=24. A second instance uses HOURS=12 to cover
// the 12-hour wrap. Expectations for the snooze case follow ALARM_SNOOZE_EN.

module tb_alarm_mode_ctrl;

   localparam int unsigned DIV = 4;

   localparam logic [4:0] B_C = 5'b10000;
   localparam logic [4:0] B_U = 5'b01000;
   localparam logic [4:0] B_D = 5'b00100;
   localparam logic [4:0] B_L = 5'b00010;
   localparam logic [4:0] B_R = 5'b00001;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  btn   = '0;
   logic [4:0]  btn12 = '0;

   logic [15:0] digits, digits12;
   logic [4:0]  mode_led, mode_led12;
   logic        blink, ringing, colon;
   logic        blink12, ringing12, colon12;

   int          n_total = 0;
   int          n_pass  = 0;
   int          cyc;

   alarm_mode_ctrl #(.TICK_DIV(DIV), .HOURS(24), .RING_SECS(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_c    (btn[4]),
      .btn_u    (btn[3]),
      .btn_d    (btn[2]),
      .btn_l    (btn[1]),
      .btn_r    (btn[0]),
      .digits   (digits),
      .mode_led (mode_led),
      .blink    (blink),
      .ringing  (ringing),
      .colon    (colon)
   );

   alarm_mode_ctrl #(.TICK_DIV(DIV), .HOURS(12), .RING_SECS(3)) dut12 (
      .clk      (clk),
      .rst      (rst),
      .btn_c    (btn12[4]),
      .btn_u    (btn12[3]),
      .btn_d    (btn12[2]),
      .btn_l    (btn12[1]),
      .btn_r    (btn12[0]),
      .digits   (digits12),
      .mode_led (mode_led12),
      .blink    (blink12),
      .ringing  (ringing12),
      .colon    (colon12)
   );

   always #5 clk = ~clk;

   // Counts edges since the last reset release. A 1 s tick lands on every
   // edge where cyc becomes a multiple of DIV.
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic press(input logic [4:0] b, input bit on12);
      if (on12) btn12 = b;
      else      btn   = b;
      @(posedge clk);
      #1;
      btn   = '0;
      btn12 = '0;
   endtask

   task automatic wait_ticks(input int n);
      int seen;
      int guard;
      seen  = 0;
      guard = 0;
      while (seen < n && guard < int'(DIV) * n + 8) begin
         @(posedge clk);
         #1;
         guard++;
         if (cyc % int'(DIV) == 0) seen++;
      end
      if (seen != n) check("tick_wait", seen, n);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit saw0, saw1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // Reset state.
      check("rst_digits",   digits,   16'h0000);
      check("rst_mode",     mode_led, 5'b00001);
      check("rst_blink",    blink,    1'b0);
      check("rst_colon",    colon,    1'b0);
      check("rst_ringing",  ringing,  1'b0);
      check("rst_digits12", digits12, 16'h0000);
      rst = 1'b1;

      // 239 edges give 59 ticks, and the 240th edge rolls the minute over.
      repeat (239) @(posedge clk);
      #1;
      check("idle239_digits", digits, 16'h0000);
      @(posedge clk);
      #1;
      check("idle240_digits", digits,   16'h0001);
      check("idle240_mode",   mode_led, 5'b00001);
      saw0 = 0; saw1 = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (colon) saw1 = 1; else saw0 = 1;
      end
      check("clock_colon_toggles", {saw0, saw1}, 2'b11);

      // Enter SET_TH, decrement hour 0 -> 23, check blink, then go back to SET_AM.
      press(B_C, 0);
      check("setth_mode",  mode_led, 5'b00010);
      check("setth_colon", colon,    1'b1);
      press(B_D, 0);
      check("hr_dec_wrap", digits, 16'h2301);
      saw0 = 0; saw1 = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (blink) saw1 = 1; else saw0 = 1;
      end
      check("setth_blink_toggles", {saw0, saw1}, 2'b11);
      press(B_L, 0);
      check("left_to_setam", mode_led, 5'b10000);
      check("setam_shows_alarm", digits, 16'h0000);

      // Set the time to 23:59:00. A two-button press must change nothing.
      press(B_R, 0);
      check("right_to_setth", mode_led, 5'b00010);
      press(B_R, 0);
      check("right_to_settm", mode_led, 5'b00100);
      press(B_D, 0);
      press(B_D, 0);
      check("min_dec_wrap", digits, 16'h2359);
      press(B_U | B_D, 0);
      check("multi_btn_digits", digits,   16'h2359);
      check("multi_btn_mode",   mode_led, 5'b00100);
      press(B_C, 0);
      check("back_to_clock", mode_led, 5'b00001);
      wait_ticks(59);
      check("at_235959",    digits,  16'h2359);
      check("pre_wrap_ring", ringing, 1'b0);
      wait_ticks(1);
      check("wrap_24h",      digits,   16'h0000);
      check("alarm0000_ring", ringing, 1'b1);
      check("ring_mode",      mode_led, 5'b00000);
      press(B_L, 0);
      check("dismiss_ring",   ringing,  1'b0);
      check("dismiss_mode",   mode_led, 5'b00001);
      check("dismiss_digits", digits,   16'h0000);

      // Edit the alarm hour, then assert reset asynchronously mid-cycle.
      press(B_C, 0);
      press(B_L, 0);
      press(B_L, 0);
      check("setah_mode", mode_led, 5'b01000);
      press(B_U, 0);
      check("ahr_inc", digits, 16'h0100);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("async_rst_digits",  digits,   16'h0000);
      check("async_rst_mode",    mode_led, 5'b00001);
      check("async_rst_blink",   blink,    1'b0);
      check("async_rst_colon",   colon,    1'b0);
      check("async_rst_ringing", ringing,  1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Alarm 00:02 and time 00:01:00. The ring starts on the 60th tick and
      // auto-dismisses after 3 ticks.
      do_reset();
      press(B_C, 0);
      press(B_L, 0);
      press(B_U, 0);
      press(B_U, 0);
      check("amin_02", digits, 16'h0002);
      press(B_R, 0);
      press(B_R, 0);
      press(B_U, 0);
      press(B_C, 0);
      check("time_0001", digits, 16'h0001);
      wait_ticks(59);
      check("no_ring_0159", ringing, 1'b0);
      wait_ticks(1);
      check("ring_0200",        ringing, 1'b1);
      check("ring_0200_digits", digits,  16'h0002);
      wait_ticks(2);
      check("ring_after_2", ringing, 1'b1);
      wait_ticks(1);
      check("ring_auto_off",      ringing,  1'b0);
      check("ring_auto_off_mode", mode_led, 5'b00001);

      // Alarm 00:58 and time 00:57:00. Dismiss with btn_u, then check 01:03.
      do_reset();
      press(B_C, 0);
      press(B_L, 0);
      press(B_D, 0);
      press(B_D, 0);
      check("amin_58", digits, 16'h0058);
      press(B_R, 0);
      press(B_R, 0);
      press(B_D, 0);
      press(B_D, 0);
      press(B_D, 0);
      press(B_C, 0);
      check("time_0057", digits, 16'h0057);
      wait_ticks(60);
      check("ring_0058", ringing, 1'b1);
      press(B_U, 0);
      check("btnu_dismiss",        ringing,  1'b0);
      check("btnu_dismiss_mode",   mode_led, 5'b00001);
      check("btnu_dismiss_digits", digits,   16'h0058);
      wait_ticks(299);
      check("no_ring_0102", ringing, 1'b0);
      check("time_0102",    digits,  16'h0102);
      wait_ticks(1);
      check("time_0103", digits, 16'h0103);
`ifdef ALARM_SNOOZE_EN
      check("snooze_ring_0103", ringing, 1'b1);
`else
      check("no_snooze_0103", ringing, 1'b0);
`endif

      // 12-hour instance: 11:59:00 plus 60 ticks wraps to 00:00.
      do_reset();
      press(B_C, 1);
      press(B_D, 1);
      check("h12_dec_wrap", digits12, 16'h1100);
      press(B_R, 1);
      press(B_D, 1);
      press(B_C, 1);
      check("h12_mode", mode_led12, 5'b00001);
      wait_ticks(59);
      check("h12_115959", digits12, 16'h1159);
      wait_ticks(1);
      check("h12_wrap", digits12, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
